open_list_arbiter: RTL and testbench
====================================

OPEN_LIST_ARBITER -- requirements
Module: open_list_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, 4, enqueue requester count; DATA_WIDTH, 32, f width; QUEUE_SIZE, 4, attached queue depth.
REQ-002 SHALL use one clock; reset is synchronous and active-low: CLK  input  1  clock; RSTn  input  1  synchronous active-low reset.
REQ-003 SHALL have ports: i_enq_valid  input  NUM_REQ  per-requester enqueue request; i_enq_f  input  NUM_REQ x DATA_WIDTH  per-requester f value; o_enq_ready  output  NUM_REQ  one-hot enqueue grant.
REQ-004 SHALL have ports: i_deq_req  input  1  pop request; o_deq_grant  output  1  pop accepted this cycle; o_deq_valid  output  1  result pulse; o_deq_f  output  DATA_WIDTH  popped f.
REQ-005 SHALL have ports: i_flush  input  1  discard queue contents; o_busy  output  1  flush in progress; o_count  output  clog2(QUEUE_SIZE)+1  tracked occupancy.
REQ-006 SHALL have queue-side ports: o_q_wrt, o_q_read, o_q_valid  output  1 each; o_q_node_f  output  DATA_WIDTH; i_q_ready_deq, i_q_ready_enq, i_q_ready_rep, i_q_valid  input  1 each; i_q_node_f  input  DATA_WIDTH  queue head.

Function
REQ-007 SHALL implement FSM RUN, COOLDOWN, FLUSH; RUN->COOLDOWN after any cycle with o_q_read=1; COOLDOWN->RUN unconditionally; RUN or COOLDOWN->FLUSH on i_flush=1; FLUSH->RUN when count==0 and no read issued that cycle.
REQ-008 SHALL keep its own occupancy counter: +1 on enqueue-only, -1 on read-only, unchanged on replace or bypass; never use queue full/empty outputs.
REQ-009 SHALL arbitrate enqueue requesters round-robin; pointer resets to 0 and moves to granted index+1 (mod NUM_REQ) after each grant; o_enq_ready at most one-hot, may depend combinationally on i_enq_valid.
REQ-010 SHALL grant dequeue in RUN only, when i_deq_req=1, i_q_ready_deq=1, and (count>0 or an enqueue is granted the same cycle); dequeue is never blocked by enqueue.
REQ-011 SHALL grant enqueue in RUN or COOLDOWN when count<QUEUE_SIZE, or in RUN when count==QUEUE_SIZE and dequeue is granted same cycle; never in FLUSH.
REQ-012 SHALL, for simultaneous enqueue+dequeue with granted f < i_q_node_f or count==0, bypass: no queue strobe, o_deq_f=granted f.
REQ-013 SHALL otherwise, for simultaneous enqueue+dequeue, require i_q_ready_rep=1 and drive o_q_wrt=o_q_read=1 with o_q_node_f=granted f; o_deq_f=i_q_node_f sampled that cycle.
REQ-014 SHALL drive o_q_valid=o_q_wrt|o_q_read; all queue strobes single-cycle and combinational from registered state plus inputs.
REQ-015 SHALL assert o_deq_valid exactly one cycle after o_deq_grant, for one cycle, with o_deq_f registered.
REQ-016 SHALL, in FLUSH, issue o_q_read whenever count>0 and i_q_ready_deq=1, with o_deq_valid held 0; o_busy=1 throughout FLUSH.
REQ-017 SHALL treat i_flush as higher priority than any same-cycle request: no grants that cycle.

Reset
REQ-018 SHALL reset: state RUN, count 0, RR pointer 0, o_deq_valid 0, o_deq_f all ones, o_busy 0, all grants/strobes 0.
REQ-019 SHALL abort any transaction on reset mid-operation; occupancy assumed to match a simultaneously reset queue.

Configuration
REQ-020 SHALL, with macro OPEN_LIST_ARBITER_STATS_EN defined, add outputs o_stat_enq, o_stat_deq, o_stat_stall (16 bits each, saturating, reset 0) counting enqueue grants, dequeue grants, and cycles with any request ungranted; without it these ports and counters SHALL be absent.

Structure
REQ-021 SHALL place the FSM state enum and default DATA_WIDTH/QUEUE_SIZE constants in shared package open_list_pkg.
REQ-022 SHALL implement the round-robin grant as sub-module rr_arbiter (parameter NUM_REQ, inputs request vector and advance strobe, output one-hot grant).

Verification
REQ-023 SHALL cover: reset, enqueue f=5,9,3 from requesters 0,1,2 -> grants in 3 cycles, count=3, o_q_wrt each cycle.
REQ-024 SHALL cover: all 4 requesters valid continuously -> grants rotate 0,1,2,3,0; none granted twice before others.
REQ-025 SHALL cover: count=4, i_deq_req=1 plus enqueue f=7, head=2 -> replace strobe, o_deq_f=2 next cycle, count stays 4; enqueue alone at count=4 -> no grant.
REQ-026 SHALL cover: head=10, enqueue f=4 with i_deq_req -> bypass, no queue strobes, o_deq_f=4, count unchanged; count=0 same result.
REQ-027 SHALL cover: dequeue granted -> next cycle COOLDOWN, i_deq_req ignored, enqueue still granted; then RUN.
REQ-028 SHALL cover: count=3, i_flush=1 -> three reads over 6 cycles, o_deq_valid stays 0, o_busy drops when count=0.

Source files
------------

// File: rtl/open_list_pkg.sv
// Shared types and default sizes for the open-list arbiter.
// Optional statistics counters in open_list_arbiter are enabled by OPEN_LIST_ARBITER_STATS_EN.
package open_list_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_QUEUE_SIZE = 4;
    localparam int unsigned STAT_W         = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; the pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        logic found;
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[PTR_W'(idx)]) begin
                found                = 1'b1;
                grant[PTR_W'(idx)]   = 1'b1;
                ptr_next             = PTR_W'((idx + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/open_list_arbiter.sv
// Arbitrates enqueue/dequeue traffic onto a min-ordered open-list queue, with bypass, replace and flush.
// Define OPEN_LIST_ARBITER_STATS_EN to add saturating enqueue/dequeue/stall counters.
module open_list_arbiter
    import open_list_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned QUEUE_SIZE = DEF_QUEUE_SIZE
) (
    input  logic                                CLK,
    input  logic                                RSTn,
    input  logic [NUM_REQ-1:0]                  i_enq_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  i_enq_f,
    output logic [NUM_REQ-1:0]                  o_enq_ready,
    input  logic                                i_deq_req,
    output logic                                o_deq_grant,
    output logic                                o_deq_valid,
    output logic [DATA_WIDTH-1:0]               o_deq_f,
    input  logic                                i_flush,
    output logic                                o_busy,
    output logic [$clog2(QUEUE_SIZE):0]         o_count,
    output logic                                o_q_wrt,
    output logic                                o_q_read,
    output logic                                o_q_valid,
    output logic [DATA_WIDTH-1:0]               o_q_node_f,
    input  logic                                i_q_ready_deq,
    input  logic                                i_q_ready_enq,
    input  logic                                i_q_ready_rep,
    input  logic                                i_q_valid,
    input  logic [DATA_WIDTH-1:0]               i_q_node_f
`ifdef OPEN_LIST_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0]                   o_stat_enq,
    output logic [STAT_W-1:0]                   o_stat_deq,
    output logic [STAT_W-1:0]                   o_stat_stall
`endif
);

    localparam int unsigned CNT_W = $clog2(QUEUE_SIZE) + 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    logic [NUM_REQ-1:0]    cand;
    logic [DATA_WIDTH-1:0] cand_f;
    logic                  any_cand;
    logic                  empty;
    logic                  full;
    logic                  deq_base;
    logic                  enq_room;
    logic                  head_lose;
    logic                  enq_ok;
    logic                  deq_ok;
    logic                  bypass;
    logic                  flush_rd;
    logic                  q_wrt;
    logic                  q_read;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk     (CLK),
        .rst_n   (RSTn),
        .req     (i_enq_valid),
        .advance (enq_ok),
        .grant   (cand)
    );

    // Grant decisions; a flush request or reset suppresses every grant this cycle.
    always_comb begin
        cand_f = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand[k]) begin
                cand_f = cand_f | i_enq_f[k];
            end
        end
        any_cand  = |cand;
        empty     = (count == '0);
        full      = (count == CNT_W'(QUEUE_SIZE));
        deq_base  = RSTn && !i_flush && (state == ST_RUN) && i_deq_req && i_q_ready_deq;
        enq_room  = RSTn && !i_flush &&
                    (((state != ST_FLUSH) && (count < CNT_W'(QUEUE_SIZE))) ||
                     ((state == ST_RUN) && full && deq_base));
        // An invalid head cannot be returned, so it is treated like an empty queue.
        head_lose = empty || !i_q_valid || (cand_f < i_q_node_f);

        enq_ok = 1'b0;
        if (deq_base && !empty) begin
            enq_ok = any_cand && enq_room && (head_lose || i_q_ready_rep);
        end else if (deq_base) begin
            enq_ok = any_cand && enq_room;
        end else begin
            enq_ok = any_cand && enq_room && i_q_ready_enq;
        end

        deq_ok   = deq_base && (!empty || enq_ok);
        bypass   = enq_ok && deq_ok && head_lose;
        flush_rd = RSTn && (state == ST_FLUSH) && !empty && i_q_ready_deq;
        q_wrt    = enq_ok && !bypass;
        q_read   = (deq_ok && !bypass) || flush_rd;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (i_flush) begin
                    state_next = ST_FLUSH;
                end else if (q_read) begin
                    state_next = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                state_next = i_flush ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                if (empty && !q_read) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase

        count_next = count;
        if (q_wrt && !q_read) begin
            count_next = count + CNT_W'(1);
        end else if (q_read && !q_wrt) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state       <= ST_RUN;
            count       <= '0;
            o_deq_valid <= 1'b0;
            o_deq_f     <= '1;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            o_deq_valid <= deq_ok;
            o_busy      <= (state_next == ST_FLUSH);
            if (deq_ok) begin
                o_deq_f <= bypass ? cand_f : i_q_node_f;
            end
        end
    end

    assign o_enq_ready = cand & {NUM_REQ{enq_ok}};
    assign o_deq_grant = deq_ok;
    assign o_q_wrt     = q_wrt;
    assign o_q_read    = q_read;
    assign o_q_valid   = q_wrt | q_read;
    assign o_q_node_f  = cand_f;
    assign o_count     = count;

`ifdef OPEN_LIST_ARBITER_STATS_EN
    logic stall;

    assign stall = ((|i_enq_valid) && !enq_ok) || (i_deq_req && !deq_ok);

    // Saturating activity counters.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            o_stat_enq   <= '0;
            o_stat_deq   <= '0;
            o_stat_stall <= '0;
        end else begin
            if (enq_ok && (o_stat_enq != '1)) begin
                o_stat_enq <= o_stat_enq + STAT_W'(1);
            end
            if (deq_ok && (o_stat_deq != '1)) begin
                o_stat_deq <= o_stat_deq + STAT_W'(1);
            end
            if (stall && (o_stat_stall != '1)) begin
                o_stat_stall <= o_stat_stall + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_open_list_arbiter.sv
// Directed table-driven bench for open_list_arbiter plus round-robin and mid-run reset sequences.
module tb_open_list_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned QS = 4;
    localparam int unsigned NV = 20;

    logic                   CLK;
    logic                   RSTn;
    logic [NR-1:0]          i_enq_valid;
    logic [NR-1:0][DW-1:0]  i_enq_f;
    logic [NR-1:0]          o_enq_ready;
    logic                   i_deq_req;
    logic                   o_deq_grant;
    logic                   o_deq_valid;
    logic [DW-1:0]          o_deq_f;
    logic                   i_flush;
    logic                   o_busy;
    logic [2:0]             o_count;
    logic                   o_q_wrt;
    logic                   o_q_read;
    logic                   o_q_valid;
    logic [DW-1:0]          o_q_node_f;
    logic                   i_q_ready_deq;
    logic                   i_q_ready_enq;
    logic                   i_q_ready_rep;
    logic                   i_q_valid;
    logic [DW-1:0]          i_q_node_f;

    open_list_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .QUEUE_SIZE (QS)
    ) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .i_enq_valid   (i_enq_valid),
        .i_enq_f       (i_enq_f),
        .o_enq_ready   (o_enq_ready),
        .i_deq_req     (i_deq_req),
        .o_deq_grant   (o_deq_grant),
        .o_deq_valid   (o_deq_valid),
        .o_deq_f       (o_deq_f),
        .i_flush       (i_flush),
        .o_busy        (o_busy),
        .o_count       (o_count),
        .o_q_wrt       (o_q_wrt),
        .o_q_read      (o_q_read),
        .o_q_valid     (o_q_valid),
        .o_q_node_f    (o_q_node_f),
        .i_q_ready_deq (i_q_ready_deq),
        .i_q_ready_enq (i_q_ready_enq),
        .i_q_ready_rep (i_q_ready_rep),
        .i_q_valid     (i_q_valid),
        .i_q_node_f    (i_q_node_f)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  ev;
        logic [31:0] f;
        logic        deq;
        logic [31:0] head;
        logic        flush;
        logic        rdq;
        logic [3:0]  x_rdy;
        logic        x_dg;
        logic        x_wrt;
        logic        x_rd;
        logic [2:0]  x_cnt;
        logic        x_dv;
        logic [31:0] x_df;
        logic        x_busy;
    } vec_t;

    vec_t tbl [NV];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [3:0] ev, input logic [31:0] f, input logic deq,
                                input logic [31:0] head, input logic flush, input logic rdq,
                                input logic [3:0] rdy, input logic dg, input logic wrt,
                                input logic rd, input logic [2:0] cnt, input logic dv,
                                input logic [31:0] df, input logic busy);
        vec_t v;
        v.ev = ev; v.f = f; v.deq = deq; v.head = head; v.flush = flush; v.rdq = rdq;
        v.x_rdy = rdy; v.x_dg = dg; v.x_wrt = wrt; v.x_rd = rd; v.x_cnt = cnt;
        v.x_dv = dv; v.x_df = df; v.x_busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ev, input logic [31:0] f, input logic deq,
                         input logic [31:0] head, input logic flush, input logic rdq);
        i_enq_valid = ev;
        for (int k = 0; k < int'(NR); k++) i_enq_f[k] = f;
        i_deq_req     = deq;
        i_q_node_f    = head;
        i_flush       = flush;
        i_q_ready_deq = rdq;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // in: ev, f, deq, head, flush, rdq | exp: rdy, dg, wrt, rd, cnt, dv, df, busy
        tbl[0]  = mk(4'h1,  5, 1'b0,  0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 0, 1'b0);
        tbl[1]  = mk(4'h2,  9, 1'b0,  0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 0, 1'b0);
        tbl[2]  = mk(4'h4,  3, 1'b0,  0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 0, 1'b0);
        tbl[3]  = mk(4'h0,  0, 1'b1,  3, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 3, 1'b0);
        tbl[4]  = mk(4'h8, 20, 1'b1,  5, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 0, 1'b0);
        tbl[5]  = mk(4'h1, 11, 1'b0,  5, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 0, 1'b0);
        tbl[6]  = mk(4'h2,  1, 1'b0,  5, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 0, 1'b0);
        tbl[7]  = mk(4'h2,  7, 1'b1,  2, 1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 2, 1'b0);
        tbl[8]  = mk(4'h0,  0, 1'b0,  5, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 0, 1'b0);
        tbl[9]  = mk(4'h4,  4, 1'b1, 10, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 4, 1'b0);
        tbl[10] = mk(4'h0,  0, 1'b1,  6, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 6, 1'b0);
        tbl[11] = mk(4'h8,  9, 1'b1,  6, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 0, 1'b1);
        tbl[12] = mk(4'hF,  9, 1'b1,  6, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 0, 1'b1);
        tbl[13] = mk(4'hF,  9, 1'b1,  6, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 0, 1'b1);
        tbl[14] = mk(4'hF,  9, 1'b1,  6, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 0, 1'b1);
        tbl[15] = mk(4'hF,  9, 1'b1,  6, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 0, 1'b1);
        tbl[16] = mk(4'hF,  9, 1'b1,  6, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 0, 1'b1);
        tbl[17] = mk(4'hF,  9, 1'b1,  6, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 0, 1'b0);
        tbl[18] = mk(4'h8,  8, 1'b1,  2, 1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8, 1'b0);
        tbl[19] = mk(4'h0,  0, 1'b1,  2, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 0, 1'b0);

        i_q_ready_enq = 1'b1;
        i_q_ready_rep = 1'b1;
        i_q_valid     = 1'b1;

        // Reset with requests pending: nothing may be granted or strobed.
        RSTn = 1'b0;
        drive(4'hF, 32'd1, 1'b1, 32'd0, 1'b0, 1'b1);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_enq_ready", 32'(o_enq_ready), 32'h0);
        chk("rst_deq_grant", 32'(o_deq_grant), 32'h0);
        chk("rst_q_valid",   32'(o_q_valid),   32'h0);
        chk("rst_count",     32'(o_count),     32'h0);
        chk("rst_deq_valid", 32'(o_deq_valid), 32'h0);
        chk("rst_deq_f",     o_deq_f,          32'hFFFF_FFFF);
        chk("rst_busy",      32'(o_busy),      32'h0);
        RSTn = 1'b1;

        for (int i = 0; i < int'(NV); i++) begin
            drive(tbl[i].ev, tbl[i].f, tbl[i].deq, tbl[i].head, tbl[i].flush, tbl[i].rdq);
            #3;
            chk($sformatf("v%0d_enq_ready", i), 32'(o_enq_ready), 32'(tbl[i].x_rdy));
            chk($sformatf("v%0d_deq_grant", i), 32'(o_deq_grant), 32'(tbl[i].x_dg));
            chk($sformatf("v%0d_q_wrt", i),     32'(o_q_wrt),     32'(tbl[i].x_wrt));
            chk($sformatf("v%0d_q_read", i),    32'(o_q_read),    32'(tbl[i].x_rd));
            chk($sformatf("v%0d_q_valid", i),   32'(o_q_valid),   32'(tbl[i].x_wrt | tbl[i].x_rd));
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_count", i),     32'(o_count),     32'(tbl[i].x_cnt));
            chk($sformatf("v%0d_deq_valid", i), 32'(o_deq_valid), 32'(tbl[i].x_dv));
            chk($sformatf("v%0d_busy", i),      32'(o_busy),      32'(tbl[i].x_busy));
            if (tbl[i].x_dv) begin
                chk($sformatf("v%0d_deq_f", i), o_deq_f, tbl[i].x_df);
            end
        end

        // All requesters held valid: grants rotate 0,1,2,3 then 0 again via a replace at full.
        for (int i = 0; i < 5; i++) begin
            drive(4'hF, 32'd100, (i == 4), 32'd0, 1'b0, 1'b1);
            #3;
            chk($sformatf("rot%0d_enq_ready", i), 32'(o_enq_ready), 32'(1) << (i % 4));
            chk($sformatf("rot%0d_deq_grant", i), 32'(o_deq_grant), 32'(i == 4));
            chk($sformatf("rot%0d_q_wrt", i),     32'(o_q_wrt),     32'h1);
            @(posedge CLK);
            #1;
            chk($sformatf("rot%0d_count", i), 32'(o_count), 32'((i < 4) ? i + 1 : 4));
        end
        chk("rot_deq_valid", 32'(o_deq_valid), 32'h1);
        chk("rot_deq_f",     o_deq_f,          32'h0);

        // Reset mid-run: state, occupancy and pointer all return to initial values.
        RSTn = 1'b0;
        drive(4'hF, 32'd100, 1'b1, 32'd0, 1'b0, 1'b1);
        #3;
        chk("mrst_enq_ready", 32'(o_enq_ready), 32'h0);
        @(posedge CLK);
        #1;
        chk("mrst_count",     32'(o_count),     32'h0);
        chk("mrst_deq_valid", 32'(o_deq_valid), 32'h0);
        chk("mrst_deq_f",     o_deq_f,          32'hFFFF_FFFF);
        RSTn = 1'b1;
        drive(4'hF, 32'd100, 1'b0, 32'd0, 1'b0, 1'b1);
        #3;
        chk("mrst_ptr_grant", 32'(o_enq_ready), 32'h1);
        @(posedge CLK);
        #1;
        chk("mrst_count_after", 32'(o_count), 32'h1);
        drive(4'h0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
